// File: rtl/csa_pipe_adder.sv
// Two-stage pipelined carry-select adder/subtractor with valid/ready handshake.
// Optional sticky overflow flag when CSA_OVF_STICKY_EN is defined.

module csa_slice #(
  parameter int BLOCK = 4
) (
  input  logic [BLOCK-1:0] a,
  input  logic [BLOCK-1:0] b,
  output logic [BLOCK-1:0] s0,
  output logic [BLOCK-1:0] s1,
  output logic             c0,
  output logic             c1
);
  assign {c0, s0} = {1'b0, a} + {1'b0, b};
  assign {c1, s1} = {1'b0, a} + {1'b0, b} + {{BLOCK{1'b0}}, 1'b1};
endmodule

module csa_pipe_adder #(
  parameter int WIDTH = 16,
  parameter int BLOCK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
`ifdef CSA_OVF_STICKY_EN
  ,
  input  logic             ovf_clr,
  output logic             ovf_sticky
`endif
);
  localparam int NBLK   = WIDTH / BLOCK;
  localparam int STAGES = 2;

  if (WIDTH < 4 || WIDTH > 32 || (WIDTH % BLOCK) != 0) begin : g_bad_cfg
    $error("csa_pipe_adder: WIDTH must be 4..32 and a multiple of BLOCK");
  end

  logic [STAGES:1] vld_pipe;
  logic            en1, en2;

  assign out_valid = vld_pipe[2];
  assign en2       = !vld_pipe[2] || out_ready;
  assign en1       = en2 || !vld_pipe[1];
  assign in_ready  = en1;

  // Stage 1: both carry-in hypotheses for every slice
  logic [WIDTH-1:0]            beff;
  logic                        ceff;
  logic [NBLK-1:0][BLOCK-1:0]  ps0, ps1;
  logic [NBLK-1:0]             pc0, pc1;

  assign beff = sub ? ~b : b;
  assign ceff = sub ? 1'b1 : cin;

  csa_slice #(.BLOCK(BLOCK)) u_slice [NBLK-1:0] (
    .a  (a),
    .b  (beff),
    .s0 (ps0),
    .s1 (ps1),
    .c0 (pc0),
    .c1 (pc1)
  );

  logic [NBLK-1:0][BLOCK-1:0] s1_s0, s1_s1;
  logic [NBLK-1:0]            s1_c0, s1_c1;
  logic                       s1_cin, s1_as, s1_bs;

  always_ff @(posedge clk) begin
    if (en1 && in_valid) begin
      s1_s0  <= ps0;
      s1_s1  <= ps1;
      s1_c0  <= pc0;
      s1_c1  <= pc1;
      s1_cin <= ceff;
      s1_as  <= a[WIDTH-1];
      s1_bs  <= beff[WIDTH-1];
    end
  end

  // Stage 2: ripple the block carry LSB-first and pick each slice
  logic [NBLK:0]      bc;
  logic [WIDTH-1:0]   sum_n;
  logic               ovf_n;

  always_comb begin
    bc    = '0;
    sum_n = '0;
    bc[0] = s1_cin;
    for (int i = 0; i < NBLK; i++) begin
      sum_n[i*BLOCK +: BLOCK] = bc[i] ? s1_s1[i] : s1_s0[i];
      bc[i+1]                 = bc[i] ? s1_c1[i] : s1_c0[i];
    end
    ovf_n = (s1_as == s1_bs) && (sum_n[WIDTH-1] != s1_as);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
    end else begin
      if (en1) vld_pipe[1] <= in_valid;
      if (en2) vld_pipe[2] <= vld_pipe[1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum  <= '0;
      cout <= 1'b0;
      ovf  <= 1'b0;
    end else if (en2 && vld_pipe[1]) begin
      sum  <= sum_n;
      cout <= bc[NBLK];
      ovf  <= ovf_n;
    end
  end

`ifdef CSA_OVF_STICKY_EN
  // Set has priority over clear so a same-cycle overflow is never lost
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          ovf_sticky <= 1'b0;
    else if (out_valid && out_ready && ovf) ovf_sticky <= 1'b1;
    else if (ovf_clr)                    ovf_sticky <= 1'b0;
  end
`endif

endmodule

// File: tb/tb_csa_pipe_adder.sv
// Scoreboard bench for csa_pipe_adder (WIDTH=16, BLOCK=4); exercises
// ovf_sticky as well when CSA_OVF_STICKY_EN is defined.

module tb_csa_pipe_adder;
  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_ready, cin, sub;
  logic        out_valid, out_ready, cout, ovf;
  logic [15:0] a, b, sum;
`ifdef CSA_OVF_STICKY_EN
  logic        ovf_clr, ovf_sticky;
`endif

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit lat_on = 1'b0;

  typedef struct {
    logic [15:0] s;
    logic        c;
    logic        o;
    int          acc;
    bit          lat;
  } exp_t;
  exp_t sb[$];

  csa_pipe_adder #(.WIDTH(16), .BLOCK(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
`ifdef CSA_OVF_STICKY_EN
    ,
    .ovf_clr   (ovf_clr),
    .ovf_sticky(ovf_sticky)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [15:0] xa, xb, input logic xc, xs);
    exp_t e;
    logic [15:0] be;
    logic [16:0] full;
    be   = xs ? ~xb : xb;
    full = {1'b0, xa} + {1'b0, be} + {16'b0, (xs ? 1'b1 : xc)};
    e.s  = full[15:0];
    e.c  = full[16];
    e.o  = (xa[15] == be[15]) && (e.s[15] != xa[15]);
    e.acc = 0;
    e.lat = 1'b0;
    return e;
  endfunction

  // Monitor: pop/compare on output transfer, push on input transfer
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && out_ready) begin
        total++;
        assert (sb.size() != 0) else begin
          bad++;
          $error("FAIL sb_underflow got=%0h exp=expected_entry", sum);
        end
        if (sb.size() != 0) begin
          exp_t e;
          e = sb.pop_front();
          chk("sb_sum", sum, e.s);
          chk("sb_cout", cout, e.c);
          chk("sb_ovf", ovf, e.o);
          if (e.lat) chk("latency", cyc - e.acc, 2);
        end
      end
      if (in_valid && in_ready) begin
        exp_t e;
        e = model(a, b, cin, sub);
        e.acc = cyc;
        e.lat = lat_on;
        sb.push_back(e);
      end
    end
  end

  task automatic send(input logic [15:0] xa, xb, input logic xc, xs);
    bit ok;
    ok = 1'b0;
    a = xa; b = xb; cin = xc; sub = xs; in_valid = 1'b1;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      ok = in_ready;
    end
    if (!ok) chk("send_timeout", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic send_chk(input string tag, input logic [15:0] xa, xb, input logic xc, xs,
                          input logic [15:0] es, input logic ec, eo);
    send(xa, xb, xc, xs);
    @(posedge clk);
    @(negedge clk);
    chk({tag, "_valid"}, out_valid, 1);
    chk({tag, "_sum"}, sum, es);
    chk({tag, "_cout"}, cout, ec);
    chk({tag, "_ovf"}, ovf, eo);
  endtask

  task automatic drain();
    for (int i = 0; i < 1000 && (sb.size() != 0 || out_valid); i++) @(posedge clk);
    #1;
    chk("drain", sb.size(), 0);
  endtask

  initial begin
    int t0;
    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    out_ready = 1'b1;
`ifdef CSA_OVF_STICKY_EN
    ovf_clr = 1'b0;
`endif
    #3;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_sum", sum, 0);
    chk("rst_cout", cout, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_in_ready", in_ready, 1);
`ifdef CSA_OVF_STICKY_EN
    chk("rst_sticky", ovf_sticky, 0);
`endif
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", in_ready, 1);

    // Directed arithmetic cases with exact-latency checks
    lat_on = 1'b1;
    send_chk("wrap", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    send_chk("sovf", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
`ifdef CSA_OVF_STICKY_EN
    @(posedge clk); #1;
    chk("sticky_set", ovf_sticky, 1);
    repeat (2) @(posedge clk);
    #1 chk("sticky_hold", ovf_sticky, 1);
    ovf_clr = 1'b1;
    @(posedge clk); #1;
    ovf_clr = 1'b0;
    chk("sticky_clr", ovf_sticky, 0);
`endif
    send_chk("sub", 16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    drain();

    // Back-to-back throughput: 8 transfers in 8 cycles
    t0 = cyc;
    for (int i = 0; i < 8; i++) send(16'(i * 16'h1111), 16'(16'h0F0F ^ i), i[0], i[1]);
    chk("throughput", cyc - t0, 8);
    drain();

    // Stall: fill both stages, third set must wait
    lat_on = 1'b0;
    out_ready = 1'b0;
    a = 16'h0001; b = 16'h0001; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    @(negedge clk); chk("fill1_ready", in_ready, 1);
    @(posedge clk); #1 a = 16'h0002; b = 16'h0002;
    @(negedge clk); chk("fill2_ready", in_ready, 1);
    @(posedge clk); #1 a = 16'h0003; b = 16'h0003;
    @(negedge clk); chk("full_ready", in_ready, 0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); @(negedge clk);
      chk("stall_ready", in_ready, 0);
      chk("stall_valid", out_valid, 1);
      chk("stall_hold", sum, 16'h0002);
    end
    @(posedge clk); #1 out_ready = 1'b1;
    @(negedge clk); chk("pop_push_ready", in_ready, 1);
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk);
    chk("stream2_valid", out_valid, 1);
    chk("stream2_sum", sum, 16'h0004);
    @(posedge clk); @(negedge clk);
    chk("stream3_valid", out_valid, 1);
    chk("stream3_sum", sum, 16'h0006);
    drain();

    // Random operands with random backpressure
    for (int n = 0; n < 100; n++) begin
      bit ok;
      ok = 1'b0;
      a = 16'($urandom); b = 16'($urandom);
      cin = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1));
      in_valid = 1'b1;
      for (int g = 0; g < 200 && !ok; g++) begin
        out_ready = 1'($urandom_range(0, 1));
        @(negedge clk);
        ok = in_ready;
        @(posedge clk); #1;
      end
      if (!ok) chk("rand_timeout", in_ready, 1);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    drain();

    // Reset with a transfer in flight
    lat_on = 1'b1;
    send(16'h1234, 16'h1111, 1'b0, 1'b0);
    rst_n = 1'b0;
    sb.delete();
    #1;
    chk("midrst_valid", out_valid, 0);
    chk("midrst_ready", in_ready, 1);
    @(posedge clk); @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("postrst_quiet", out_valid, 0);
    end
    send_chk("after_rst", 16'h1234, 16'h0FF0, 1'b0, 1'b1, 16'h0244, 1'b1, 1'b0);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout got=%0d exp=finish", cyc);
    $fatal(1, "timeout");
  end
endmodule
